// File: rtl/control.sv
// Main decoder of the single-cycle MIPS-subset core: instruction -> mux selects and unit control words.
// Zero-cycle combinational decode gated by a run flag; no backpressure, outputs held at 0 until the first clock after reset.
module control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] curr_instr,
  output logic        cm_rf_write_addr,
  output logic        cm_rf_write_data,
  output logic        cm_alu_num2,
  output logic [2:0]  cw_npc_jump_mode,
  output logic        cw_pc_enable,
  output logic        cw_im_enable,
  output logic        cw_rf_write_enable,
  output logic [4:0]  cw_alu_op,
  output logic [2:0]  cw_ext_mode,
  output logic        cw_dm_write_enable
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_OR   = 5'd2;
  localparam logic [4:0] ALU_PASS = 5'd3;

  localparam logic [2:0] EXT_ZERO = 3'd0;
  localparam logic [2:0] EXT_SIGN = 3'd1;
  localparam logic [2:0] EXT_HIGH = 3'd2;

  localparam logic [2:0] NPC_SEQ  = 3'd0;
  localparam logic [2:0] NPC_BEQ  = 3'd1;

  logic       run;
  logic [5:0] op;
  logic [5:0] funct;

  logic       dec_rf_write_addr;
  logic       dec_rf_write_data;
  logic       dec_alu_num2;
  logic [2:0] dec_npc_jump_mode;
  logic       dec_rf_write_enable;
  logic [4:0] dec_alu_op;
  logic [2:0] dec_ext_mode;
  logic       dec_dm_write_enable;

  assign op    = curr_instr[31:26];
  assign funct = curr_instr[5:0];

  // Run flag: cleared asynchronously, set on the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_comb begin
    dec_rf_write_addr   = 1'b0;
    dec_rf_write_data   = 1'b0;
    dec_alu_num2        = 1'b0;
    dec_npc_jump_mode   = NPC_SEQ;
    dec_rf_write_enable = 1'b0;
    dec_alu_op          = ALU_ADD;
    dec_ext_mode        = EXT_ZERO;
    dec_dm_write_enable = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU || funct == FN_SUBU) begin
          dec_rf_write_addr   = 1'b1;
          dec_rf_write_enable = 1'b1;
          dec_alu_op          = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
        end
      end
      OP_ORI: begin
        dec_alu_num2        = 1'b1;
        dec_rf_write_enable = 1'b1;
        dec_alu_op          = ALU_OR;
      end
      OP_LUI: begin
        dec_alu_num2        = 1'b1;
        dec_rf_write_enable = 1'b1;
        dec_alu_op          = ALU_PASS;
        dec_ext_mode        = EXT_HIGH;
      end
      OP_LW: begin
        dec_rf_write_data   = 1'b1;
        dec_alu_num2        = 1'b1;
        dec_rf_write_enable = 1'b1;
        dec_ext_mode        = EXT_SIGN;
      end
      OP_SW: begin
        dec_alu_num2        = 1'b1;
        dec_ext_mode        = EXT_SIGN;
        dec_dm_write_enable = 1'b1;
      end
      OP_BEQ: begin
        dec_npc_jump_mode   = NPC_BEQ;
        dec_alu_op          = ALU_SUB;
        dec_ext_mode        = EXT_SIGN;
      end
      default: ;
    endcase
  end

  // Every output, selects included, is forced to 0 while not running.
  always_comb begin
    cm_rf_write_addr   = run & dec_rf_write_addr;
    cm_rf_write_data   = run & dec_rf_write_data;
    cm_alu_num2        = run & dec_alu_num2;
    cw_npc_jump_mode   = run ? dec_npc_jump_mode : 3'd0;
    cw_pc_enable       = run;
    cw_im_enable       = run;
    cw_rf_write_enable = run & dec_rf_write_enable;
    cw_alu_op          = run ? dec_alu_op : 5'd0;
    cw_ext_mode        = run ? dec_ext_mode : 3'd0;
    cw_dm_write_enable = run & dec_dm_write_enable;
  end

endmodule

// File: tb/tb_control.sv
// Bench for control: decode table vectors plus reset and run-flag sequences.
module tb_control;

  logic        clk;
  logic        rst_n;
  logic [31:0] curr_instr;
  logic        cm_rf_write_addr;
  logic        cm_rf_write_data;
  logic        cm_alu_num2;
  logic [2:0]  cw_npc_jump_mode;
  logic        cw_pc_enable;
  logic        cw_im_enable;
  logic        cw_rf_write_enable;
  logic [4:0]  cw_alu_op;
  logic [2:0]  cw_ext_mode;
  logic        cw_dm_write_enable;

  int errors = 0;
  int checks = 0;

  control dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .curr_instr        (curr_instr),
    .cm_rf_write_addr  (cm_rf_write_addr),
    .cm_rf_write_data  (cm_rf_write_data),
    .cm_alu_num2       (cm_alu_num2),
    .cw_npc_jump_mode  (cw_npc_jump_mode),
    .cw_pc_enable      (cw_pc_enable),
    .cw_im_enable      (cw_im_enable),
    .cw_rf_write_enable(cw_rf_write_enable),
    .cw_alu_op         (cw_alu_op),
    .cw_ext_mode       (cw_ext_mode),
    .cw_dm_write_enable(cw_dm_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: rfaddr rfdata alunum2 npc[3] pcen imen rfwe aluop[5] ext[3] dmwe = 18 bits.
  function automatic logic [17:0] mk(input logic rfaddr, input logic rfdata, input logic alunum2,
                                     input logic [2:0] npc, input logic run, input logic rfwe,
                                     input logic [4:0] aluop, input logic [2:0] ext, input logic dmwe);
    return {rfaddr, rfdata, alunum2, npc, run, run, rfwe, aluop, ext, dmwe};
  endfunction

  function automatic logic [17:0] obs();
    return {cm_rf_write_addr, cm_rf_write_data, cm_alu_num2, cw_npc_jump_mode,
            cw_pc_enable, cw_im_enable, cw_rf_write_enable, cw_alu_op, cw_ext_mode,
            cw_dm_write_enable};
  endfunction

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[12];
  logic [17:0] zero_out;
  logic [17:0] addu_out;

  initial begin
    zero_out = 18'd0;
    addu_out = mk(1, 0, 0, 3'd0, 1, 1, 5'd0, 3'd0, 0);

    vecs[0]  = '{"nop",        32'h00000000, mk(0, 0, 0, 3'd0, 1, 0, 5'd0, 3'd0, 0)};
    vecs[1]  = '{"addu",       32'h00430821, addu_out};
    vecs[2]  = '{"subu",       32'h00a62023, mk(1, 0, 0, 3'd0, 1, 1, 5'd1, 3'd0, 0)};
    vecs[3]  = '{"lui",        32'h3c05ffff, mk(0, 0, 1, 3'd0, 1, 1, 5'd3, 3'd2, 0)};
    vecs[4]  = '{"ori",        32'h34c64242, mk(0, 0, 1, 3'd0, 1, 1, 5'd2, 3'd0, 0)};
    vecs[5]  = '{"lw",         32'h8c410008, mk(0, 1, 1, 3'd0, 1, 1, 5'd0, 3'd1, 0)};
    vecs[6]  = '{"sw",         32'hac410010, mk(0, 0, 1, 3'd0, 1, 0, 5'd0, 3'd1, 1)};
    vecs[7]  = '{"beq",        32'h114afff9, mk(0, 0, 0, 3'd1, 1, 0, 5'd1, 3'd1, 0)};
    vecs[8]  = '{"unk_op3f",   32'hfc000000, mk(0, 0, 0, 3'd0, 1, 0, 5'd0, 3'd0, 0)};
    vecs[9]  = '{"unk_fn3f",   32'h0000003f, mk(0, 0, 0, 3'd0, 1, 0, 5'd0, 3'd0, 0)};
    vecs[10] = '{"op02_fn21",  32'h08000021, mk(0, 0, 0, 3'd0, 1, 0, 5'd0, 3'd0, 0)};
    vecs[11] = '{"op2b_lowfn", 32'hac000021, mk(0, 0, 1, 3'd0, 1, 0, 5'd0, 3'd1, 1)};

    // Reset held with addu on the bus.
    rst_n = 1'b0;
    curr_instr = 32'h00430821;
    #1;
    chk("reset_hold", obs(), zero_out);
    @(posedge clk); #1;
    chk("reset_hold_edge", obs(), zero_out);

    // Release away from an edge: stays zero until the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("released_pre_edge", obs(), zero_out);
    @(posedge clk); #1;
    chk("first_edge_addu", obs(), addu_out);

    // Decode table, run = 1, zero-cycle response.
    foreach (vecs[i]) begin
      @(negedge clk);
      curr_instr = vecs[i].instr;
      #1;
      chk(vecs[i].name, obs(), vecs[i].exp);
    end

    // Mid-run reset with sw active: write enable must drop without a clock edge.
    @(negedge clk);
    curr_instr = 32'hac410010;
    #1;
    chk("sw_before_reset", obs(), vecs[6].exp);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_dmwe", {17'd0, cw_dm_write_enable}, 18'd0);
    chk("midrun_reset_all", obs(), zero_out);
    @(posedge clk); #1;
    chk("midrun_reset_edge", obs(), zero_out);

    // Release and instruction change together: new decode only after the edge.
    @(negedge clk);
    rst_n = 1'b1;
    curr_instr = 32'h00a62023;
    #1;
    chk("release_change_pre", obs(), zero_out);
    @(posedge clk); #1;
    chk("release_change_post", obs(), vecs[2].exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
